// File: rtl/btn_event.sv
// Press classifier behind the button debouncer: emits short-press, long-press and
// auto-repeat strobes from one debounced button level.
module btn_event #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int LONG_MS    = 1000,
   parameter int REPEAT_MS  = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic press_tick,
   output logic long_tick,
   output logic repeat_tick,
   output logic held
);

   localparam int TICKS_PER_MS = CLOCK_FREQ / 1000;
   localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_MS - 1);
   localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
   localparam logic [15:0]   REPEAT_LAST = (REPEAT_MS == 0) ? 16'd0 : 16'(REPEAT_MS - 1);

   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] prescaler, prescaler_nx;
   logic [15:0]   ms_cnt, ms_cnt_nx;
   logic          press_nx, long_nx, repeat_nx, held_nx;
   logic          ms_strobe;

   assign ms_strobe = (prescaler == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prescaler   <= '0;
         ms_cnt      <= '0;
         press_tick  <= 1'b0;
         long_tick   <= 1'b0;
         repeat_tick <= 1'b0;
         held        <= 1'b0;
      end else begin
         state       <= state_nx;
         prescaler   <= prescaler_nx;
         ms_cnt      <= ms_cnt_nx;
         press_tick  <= press_nx;
         long_tick   <= long_nx;
         repeat_tick <= repeat_nx;
         held        <= held_nx;
      end
   end

   // Release is tested first in every state so it wins over threshold and repeat.
   always_comb begin
      state_nx     = state;
      prescaler_nx = ms_strobe ? '0 : prescaler + 1'b1;
      ms_cnt_nx    = ms_cnt;
      press_nx     = 1'b0;
      long_nx      = 1'b0;
      repeat_nx    = 1'b0;
      held_nx      = 1'b0;
      case (state)
         IDLE: begin
            if (btn_level) begin
               state_nx     = PRESSED;
               prescaler_nx = '0;
               ms_cnt_nx    = '0;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               state_nx = IDLE;
               press_nx = 1'b1;
            end else if (ms_strobe) begin
               if (ms_cnt == LONG_LAST) begin
                  state_nx     = LONG;
                  long_nx      = 1'b1;
                  held_nx      = 1'b1;
                  prescaler_nx = '0;
                  ms_cnt_nx    = '0;
               end else begin
                  ms_cnt_nx = ms_cnt + 16'd1;
               end
            end
         end
         LONG: begin
            held_nx = 1'b1;
            if (!btn_level) begin
               state_nx = IDLE;
               held_nx  = 1'b0;
            end else if (REPEAT_MS != 0 && ms_strobe) begin
               if (ms_cnt == REPEAT_LAST) begin
                  repeat_nx = 1'b1;
                  ms_cnt_nx = '0;
               end else begin
                  ms_cnt_nx = ms_cnt + 16'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: two instances (repeat on / repeat off) driven by the same
// button, checked every cycle against a timing model built from elapsed-cycle counts.
module tb_btn_event;

   localparam int CF   = 10_000;
   localparam int T    = CF / 1000;
   localparam int LMS  = 5;

   logic       clk;
   logic       rst;
   logic       btn_level;
   logic [1:0] press_o, long_o, rep_o, held_o;

   int total = 0;
   int bad   = 0;

   // model state per instance: 0 idle, 1 pressed, 2 long; n = edges since entry
   int rep_ms[2] = '{2, 0};
   int mode[2];
   int n[2];
   logic e_press[2], e_long[2], e_rep[2], e_held[2];
   int n_press[2], n_long[2], n_rep[2];

   btn_event #(.CLOCK_FREQ(CF), .LONG_MS(LMS), .REPEAT_MS(2)) dut (
      .clk(clk), .rst(rst), .btn_level(btn_level),
      .press_tick(press_o[0]), .long_tick(long_o[0]),
      .repeat_tick(rep_o[0]), .held(held_o[0])
   );

   btn_event #(.CLOCK_FREQ(CF), .LONG_MS(LMS), .REPEAT_MS(0)) dut_nr (
      .clk(clk), .rst(rst), .btn_level(btn_level),
      .press_tick(press_o[1]), .long_tick(long_o[1]),
      .repeat_tick(rep_o[1]), .held(held_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         e_press[i] = 1'b0;
         e_long[i]  = 1'b0;
         e_rep[i]   = 1'b0;
         if (rst) begin
            mode[i]   = 0;
            e_held[i] = 1'b0;
         end else if (mode[i] == 0) begin
            e_held[i] = 1'b0;
            if (btn_level) begin
               mode[i] = 1;
               n[i]    = 0;
            end
         end else if (mode[i] == 1) begin
            n[i]++;
            e_held[i] = 1'b0;
            if (!btn_level) begin
               mode[i]    = 0;
               e_press[i] = 1'b1;
            end else if (n[i] == LMS * T) begin
               mode[i]   = 2;
               n[i]      = 0;
               e_long[i] = 1'b1;
               e_held[i] = 1'b1;
            end
         end else begin
            n[i]++;
            if (!btn_level) begin
               mode[i]   = 0;
               e_held[i] = 1'b0;
            end else begin
               e_held[i] = 1'b1;
               if (rep_ms[i] != 0 && (n[i] % (rep_ms[i] * T)) == 0) e_rep[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("press%0d", i), press_o[i], e_press[i]);
         check($sformatf("long%0d", i),  long_o[i],  e_long[i]);
         check($sformatf("rep%0d", i),   rep_o[i],   e_rep[i]);
         check($sformatf("held%0d", i),  held_o[i],  e_held[i]);
         check($sformatf("excl%0d", i),
               (press_o[i] + long_o[i] + rep_o[i] <= 1) ? 1 : 0, 1);
         n_press[i] += press_o[i];
         n_long[i]  += long_o[i];
         n_rep[i]   += rep_o[i];
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         n_press[i] = 0;
         n_long[i]  = 0;
         n_rep[i]   = 0;
      end
   endtask

   task automatic hold(input int hi, input int lo);
      btn_level = 1'b1;
      repeat (hi) step();
      btn_level = 1'b0;
      repeat (lo) step();
   endtask

   initial begin
      rst       = 1'b1;
      btn_level = 1'b0;
      mode      = '{0, 0};
      n         = '{0, 0};
      clear_counts();

      // reset with button already down, then a press counted from rst release
      btn_level = 1'b1;
      repeat (5) step();
      rst = 1'b0;
      repeat (50) step();
      check("s1_quiet_ticks", n_press[0] + n_long[0] + n_rep[0], 0);
      step();
      check("s1_long_at_50", n_long[0], 1);
      btn_level = 1'b0;
      repeat (10) step();

      clear_counts();
      hold(30, 10);
      check("s2_press", n_press[0], 1);
      check("s2_long", n_long[0], 0);

      clear_counts();
      hold(120, 10);
      check("s3_long", n_long[0], 1);
      check("s3_rep", n_rep[0], 3);
      check("s3_press", n_press[0], 0);
      check("s3_nr_rep", n_rep[1], 0);

      clear_counts();
      hold(50, 10);
      check("s4_press", n_press[0], 1);
      check("s4_long", n_long[0], 0);

      clear_counts();
      hold(200, 10);
      check("s5_nr_long", n_long[1], 1);
      check("s5_nr_rep", n_rep[1], 0);
      check("s5_rep", n_rep[0], 7);

      // reset in the middle of a long hold, button stays down across it
      clear_counts();
      btn_level = 1'b1;
      repeat (80) step();
      rst = 1'b1;
      repeat (3) step();
      check("s6_held_cleared", held_o[0], 0);
      check("s6_pre_long", n_long[0], 1);
      check("s6_pre_rep", n_rep[0], 1);
      rst = 1'b0;
      clear_counts();
      repeat (50) step();
      check("s6_quiet", n_long[0] + n_press[0] + n_rep[0], 0);
      step();
      check("s6_relong", n_long[0], 1);
      btn_level = 1'b0;
      repeat (10) step();

      // random holds, gaps and occasional resets
      repeat (60) begin
         if ($urandom_range(0, 9) == 0) begin
            rst       = 1'b1;
            btn_level = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) step();
            rst = 1'b0;
         end else begin
            hold($urandom_range(1, 150), $urandom_range(1, 15));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
